mul_add_unit: RTL and testbench

- Operand-producing stage directly upstream of the simulation top.
- Accepts a pair of WIDTH-bit unsigned operands over a valid/ready handshake.
- Computes their product iteratively (shift-and-add, one bit per clock) and their sum.
- Presents the results as mul_res/add_res, held stable until the consumer accepts them.

---
 rtl/mul_add_pkg.sv | 8 +
 rtl/shift_add_mul.sv | 60 ++++++
 rtl/mul_add_unit.sv | 107 ++++++++++
 tb/tb_mul_add_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mul_add_pkg.sv
// Shared types and defaults for the multiply/add operand stage.
package mul_add_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam int MUL_ADD_WIDTH = 32;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-and-add multiplier: one multiplier bit per clock, fixed WIDTH steps.
module shift_add_mul #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               run,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [CW-1:0]      step_cnt,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [CW-1:0]      cnt_q, cnt_d;

    always_comb begin
        acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (run) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Product is the post-iteration accumulator so the owner can capture it on the done cycle.
    assign done     = run && (cnt_q == CW'(WIDTH - 1));
    assign product  = acc_step;
    assign step_cnt = cnt_q;

endmodule

// File: rtl/mul_add_unit.sv
// Operand stage: accepts an operand pair, returns its product (iterative) and sum.
module mul_add_unit
    import mul_add_pkg::*;
#(
    parameter int WIDTH = MUL_ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mul_a,
    input  logic [WIDTH-1:0] mul_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] mul_res,
    output logic             mul_ovf,
    output logic [WIDTH-1:0] add_res,
    output logic             add_carry,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   mul_res_q, mul_res_d;
    logic               mul_ovf_q, mul_ovf_d;
    logic [WIDTH-1:0]   add_res_q, add_res_d;
    logic               add_carry_q, add_carry_d;
    logic               start, run, mul_done;
    logic [CW-1:0]      step_cnt;
    logic [2*WIDTH-1:0] product;

    assign in_ready = (state_q == IDLE);
    assign start    = in_ready && in_valid;
    assign run      = (state_q == BUSY);

    shift_add_mul #(.WIDTH(WIDTH), .CW(CW)) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .run      (run),
        .a        (mul_a),
        .b        (mul_b),
        .step_cnt (step_cnt),
        .done     (mul_done),
        .product  (product)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        mul_res_d   = mul_res_q;
        mul_ovf_d   = mul_ovf_q;
        add_res_d   = add_res_q;
        add_carry_d = add_carry_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                {add_carry_d, add_res_d} = {1'b0, mul_a} + {1'b0, mul_b};
                busy_d  = 1'b1;
                state_d = BUSY;
            end
            BUSY: if (mul_done) begin
                mul_res_d   = product[WIDTH-1:0];
                mul_ovf_d   = |product[2*WIDTH-1:WIDTH];
                busy_d      = 1'b0;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mul_res_q   <= '0;
            mul_ovf_q   <= 1'b0;
            add_res_q   <= '0;
            add_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            mul_res_q   <= mul_res_d;
            mul_ovf_q   <= mul_ovf_d;
            add_res_q   <= add_res_d;
            add_carry_q <= add_carry_d;
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign mul_res   = mul_res_q;
    assign mul_ovf   = mul_ovf_q;
    assign add_res   = add_res_q;
    assign add_carry = add_carry_q;

endmodule

// File: tb/tb_mul_add_unit.sv
// Directed-vector bench for mul_add_unit: table of ops plus handshake/reset sequences.
module tb_mul_add_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] mul_a = '0;
    logic [W-1:0] mul_b = '0;
    logic         in_ready, out_valid, mul_ovf, add_carry, busy;
    logic [W-1:0] mul_res, add_res;

    int total = 0;
    int bad = 0;

    mul_add_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mul_res   (mul_res),
        .mul_ovf   (mul_ovf),
        .add_res   (add_res),
        .add_carry (add_carry),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] m;
        logic         o;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        mul_a = a;
        mul_b = b;
        in_valid = 1'b1;
        chk("in_ready_before_accept", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'(1));
    endtask

    // Counts edges after the accept edge until out_valid; optionally pulses a stray in_valid.
    task automatic wait_done(input int pulse_at);
        int lat;
        for (lat = 1; lat <= 100; lat++) begin
            if (lat == pulse_at) begin
                mul_a = 9;
                mul_b = 9;
                in_valid = 1'b1;
            end
            if (lat == pulse_at + 2) in_valid = 1'b0;
            @(posedge clk);
            #1;
            if (out_valid) break;
        end
        chk("latency", 64'(lat), 64'(32));
    endtask

    task automatic chk_res(input logic [W-1:0] m, input logic o, input logic [W-1:0] s, input logic c);
        chk("out_valid", 64'(out_valid), 64'(1));
        chk("mul_res", 64'(mul_res), 64'(m));
        chk("mul_ovf", 64'(mul_ovf), 64'(o));
        chk("add_res", 64'(add_res), 64'(s));
        chk("add_carry", 64'(add_carry), 64'(c));
    endtask

    task automatic chk_handoff();
        @(posedge clk);
        #1;
        chk("out_valid_after_handoff", 64'(out_valid), 64'(0));
        chk("in_ready_after_handoff", 64'(in_ready), 64'(1));
    endtask

    initial begin
        vecs[0] = '{32'd3,          32'd5,          32'd15,         1'b0, 32'd8,          1'b0};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  1'b1, 32'hFFFF_FFFE,  1'b1};
        vecs[2] = '{32'h0001_0000,  32'h0001_0000,  32'h0,          1'b1, 32'h0002_0000,  1'b0};
        vecs[3] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, 32'h0,          1'b1};
        vecs[4] = '{32'd12345,      32'd1000,       32'd12345000,   1'b0, 32'd13345,      1'b0};

        // Reset state
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_mul_res", 64'(mul_res), 64'(0));
        chk("rst_add_res", 64'(add_res), 64'(0));
        chk("rst_flags", 64'({mul_ovf, add_carry}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Table vectors, consumer always ready
        for (int i = 0; i < 5; i++) begin
            accept(vecs[i].a, vecs[i].b);
            wait_done(-10);
            chk_res(vecs[i].m, vecs[i].o, vecs[i].s, vecs[i].c);
            chk_handoff();
        end

        // Backpressure: result held for 10 cycles
        out_ready = 1'b0;
        accept(32'd7, 32'd6);
        wait_done(-10);
        chk_res(32'd42, 1'b0, 32'd13, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk_res(32'd42, 1'b0, 32'd13, 1'b0);
            chk("bp_in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        chk_handoff();

        // Stray in_valid during BUSY is ignored; 0*0
        accept(32'd0, 32'd0);
        wait_done(4);
        chk_res(32'd0, 1'b0, 32'd0, 1'b0);
        chk_handoff();
        @(posedge clk);
        #1;
        chk("stray_not_accepted", 64'(busy), 64'(0));

        // 2*0 result with full latency
        accept(32'd2, 32'd0);
        wait_done(-10);
        chk_res(32'd0, 1'b0, 32'd2, 1'b0);
        chk_handoff();

        // Asynchronous reset mid-operation
        accept(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'(1));
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_mul_res", 64'(mul_res), 64'(0));
        chk("arst_add_res", 64'(add_res), 64'(0));
        chk("arst_flags", 64'({mul_ovf, add_carry}), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        accept(32'd100, 32'd200);
        wait_done(-10);
        chk_res(32'd20000, 1'b0, 32'd300, 1'b0);
        chk_handoff();

        // Back-to-back with in_valid held high
        mul_a = 32'd4;
        mul_b = 32'd4;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_first_busy", 64'(busy), 64'(1));
        mul_a = 32'd10;
        mul_b = 32'd10;
        wait_done(-10);
        chk_res(32'd16, 1'b0, 32'd8, 1'b0);
        chk_handoff();
        @(posedge clk);
        #1;
        chk("b2b_second_busy", 64'(busy), 64'(1));
        in_valid = 1'b0;
        wait_done(-10);
        chk_res(32'd100, 1'b0, 32'd20, 1'b0);
        chk_handoff();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
